write_req_xbar_arb: RTL and testbench

WRITE_REQ_XBAR_ARB -- requirements
Module: write_req_xbar_arb

---
 rtl/vector_cache_pkg.sv | 36 +++
 rtl/write_req_xbar_arb_pkg.sv | 23 ++
 rtl/write_req_xbar_arb_if.sv | 34 +++
 rtl/write_req_xbar_arb_rr_arb.sv | 47 ++++
 rtl/write_req_xbar_arb.sv | 100 ++++++++++
 tb/tb_write_req_xbar_arb.sv | 285 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/vector_cache_pkg.sv
// vector_cache_pkg: shared vector-cache payload types.
//   input_write_cmd_pld_t : write command + data as presented by a requester
//   input_req_pld_t       : command forwarded downstream, tagged with its data-buffer entry
//   wdb_pld_t             : write-data-buffer payload (data, entry id, command copy)
package vector_cache_pkg;
    localparam int ADDR_WIDTH         = 64;
    localparam int TXNID_WIDTH        = 8;
    localparam int SIDEBAND_WIDTH     = 4;
    localparam int OPCODE_WIDTH       = 4;
    localparam int DATA_WIDTH         = 64;
    localparam int STRB_WIDTH         = DATA_WIDTH / 8;
    localparam int DB_ENTRY_IDX_WIDTH = 4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     cmd_addr;
        logic [TXNID_WIDTH-1:0]    cmd_txnid;
        logic [SIDEBAND_WIDTH-1:0] cmd_sideband;
        logic [STRB_WIDTH-1:0]     strb;
        logic [DATA_WIDTH-1:0]     data;
    } input_write_cmd_pld_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]         cmd_addr;
        logic [TXNID_WIDTH-1:0]        cmd_txnid;
        logic [SIDEBAND_WIDTH-1:0]     cmd_sideband;
        logic [OPCODE_WIDTH-1:0]       cmd_opcode;
        logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
    } input_req_pld_t;

    typedef struct packed {
        logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
        logic [STRB_WIDTH-1:0]         strb;
        logic [DATA_WIDTH-1:0]         data;
        input_req_pld_t                cmd;
    } wdb_pld_t;
endpackage

// File: rtl/write_req_xbar_arb_pkg.sv
// write_req_xbar_arb_pkg: constants and the queue-entry builder for the write
// request crossbar. Types live in vector_cache_pkg.
package write_req_xbar_arb_pkg;
    import vector_cache_pkg::*;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_WRITE = OPCODE_WIDTH'(1);

    // Tag a granted command with its data-buffer entry; command and data
    // carry the same entry id so downstream can pair them.
    function automatic wdb_pld_t build_entry(input input_write_cmd_pld_t c,
                                             input logic [DB_ENTRY_IDX_WIDTH-1:0] id);
        wdb_pld_t e;
        e.cmd.cmd_addr     = c.cmd_addr;
        e.cmd.cmd_txnid    = c.cmd_txnid;
        e.cmd.cmd_sideband = c.cmd_sideband;
        e.cmd.cmd_opcode   = OPCODE_WRITE;
        e.cmd.db_entry_id  = id;
        e.db_entry_id      = id;
        e.strb             = c.strb;
        e.data             = c.data;
        return e;
    endfunction
endpackage

// File: rtl/write_req_xbar_arb_if.sv
// write_req_xbar_arb_if: handshake bundle of the write request crossbar.
//   wr_cmd_*    : W_REQ_NUM requester ports (vld/pld in, rdy out)
//   alloc_*     : per-channel data-buffer allocator (vld/idx in, rdy out)
//   sel_wr_*    : per-channel output (vld/pld/data_pld out, rdy in)
// slave = crossbar side, master = environment side.
interface write_req_xbar_arb_if #(
    parameter int W_REQ_NUM = 8,
    parameter int OUT_NUM   = 4
) ();
    import vector_cache_pkg::*;

    logic                 [W_REQ_NUM-1:0] wr_cmd_vld;
    input_write_cmd_pld_t [W_REQ_NUM-1:0] wr_cmd_pld;
    logic                 [W_REQ_NUM-1:0] wr_cmd_rdy;

    logic [OUT_NUM-1:0]                         alloc_vld;
    logic [OUT_NUM-1:0][DB_ENTRY_IDX_WIDTH-1:0] alloc_idx;
    logic [OUT_NUM-1:0]                         alloc_rdy;

    logic           [OUT_NUM-1:0] sel_wr_vld;
    input_req_pld_t [OUT_NUM-1:0] sel_wr_pld;
    wdb_pld_t       [OUT_NUM-1:0] sel_wr_data_pld;
    logic           [OUT_NUM-1:0] sel_wr_rdy;

    modport slave (
        input  wr_cmd_vld, wr_cmd_pld, alloc_vld, alloc_idx, sel_wr_rdy,
        output wr_cmd_rdy, alloc_rdy, sel_wr_vld, sel_wr_pld, sel_wr_data_pld
    );

    modport master (
        output wr_cmd_vld, wr_cmd_pld, alloc_vld, alloc_idx, sel_wr_rdy,
        input  wr_cmd_rdy, alloc_rdy, sel_wr_vld, sel_wr_pld, sel_wr_data_pld
    );
endinterface

// File: rtl/write_req_xbar_arb_rr_arb.sv
// rr_arb: N-way round-robin arbiter.
//   req_i     : request vector
//   advance_i : a grant is being taken this cycle; pointer moves past the winner
//   grant_o   : one-hot winner (combinational), zero when no request
// The pointer names the highest-priority index and resets to 0.
module rr_arb #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, win;
    logic          found;
    int            idx;

    // Scan from the pointer, wrapping, and take the first requester.
    always_comb begin
        grant_o = '0;
        win     = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                win          = PW'(idx);
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) ptr_d = (int'(win) == N - 1) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/write_req_xbar_arb.sv
// write_req_xbar_arb: routes W_REQ_NUM write requesters to OUT_NUM channels
// by the top address bits, arbitrates each channel round-robin, tags each
// grant with a data-buffer entry from that channel's allocator and queues it
// in an OUT_DEPTH-entry FIFO per channel.
//   clk, rst : clock, async active-high reset
//   bus      : write_req_xbar_arb_if.slave (requesters, allocators, outputs)
// Grant conditions use only the registered queue count, so sel_wr_rdy never
// reaches wr_cmd_rdy/alloc_rdy combinationally and sel_wr_vld is a pure
// function of state.
module write_req_xbar_arb
    import vector_cache_pkg::*;
    import write_req_xbar_arb_pkg::*;
#(
    parameter int W_REQ_NUM = 8,
    parameter int OUT_NUM   = 4,
    parameter int OUT_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    write_req_xbar_arb_if.slave  bus
);
    localparam int TGT_W = $clog2(OUT_NUM);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    logic [OUT_NUM-1:0][W_REQ_NUM-1:0] ch_gnt;

    for (genvar ch = 0; ch < OUT_NUM; ch++) begin : g_ch
        logic [W_REQ_NUM-1:0] req, arb_gnt;
        logic                 push, pop;
        input_write_cmd_pld_t win_cmd;
        wdb_pld_t             mem [OUT_DEPTH];
        logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0]     cnt_q, cnt_d;

        always_comb begin
            req = '0;
            for (int i = 0; i < W_REQ_NUM; i++)
                req[i] = bus.wr_cmd_vld[i] &&
                         (bus.wr_cmd_pld[i].cmd_addr[ADDR_WIDTH-1 -: TGT_W] == TGT_W'(ch));
        end

        // A full queue refuses even when it is popping this cycle.
        assign push = !rst && (|req) && bus.alloc_vld[ch] && (cnt_q < CNT_W'(OUT_DEPTH));
        assign pop  = (cnt_q != '0) && bus.sel_wr_rdy[ch];

        rr_arb #(.N(W_REQ_NUM)) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req_i     (req),
            .advance_i (push),
            .grant_o   (arb_gnt)
        );

        assign ch_gnt[ch] = push ? arb_gnt : '0;

        always_comb begin
            win_cmd = '0;
            for (int i = 0; i < W_REQ_NUM; i++)
                if (arb_gnt[i]) win_cmd = bus.wr_cmd_pld[i];
        end

        always_comb begin
            cnt_d = cnt_q;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
        end

        // Payload storage is qualified by the count, so it carries no reset.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr_q] <= build_entry(win_cmd, bus.alloc_idx[ch]);
        end

        assign bus.alloc_rdy[ch]       = push;
        assign bus.sel_wr_vld[ch]      = (cnt_q != '0);
        assign bus.sel_wr_data_pld[ch] = mem[rd_ptr_q];
        assign bus.sel_wr_pld[ch]      = mem[rd_ptr_q].cmd;
    end

    // Each input targets exactly one channel, so OR-ing channel grants is safe.
    always_comb begin
        bus.wr_cmd_rdy = '0;
        for (int m = 0; m < OUT_NUM; m++) bus.wr_cmd_rdy = bus.wr_cmd_rdy | ch_gnt[m];
    end
endmodule

// File: tb/tb_write_req_xbar_arb.sv
module tb_write_req_xbar_arb;
    import vector_cache_pkg::*;

    localparam int W   = 8;
    localparam int O   = 4;
    localparam int D   = 2;
    localparam int LOG = $clog2(O);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    write_req_xbar_arb_if #(.W_REQ_NUM(W), .OUT_NUM(O)) bus ();

    write_req_xbar_arb #(.W_REQ_NUM(W), .OUT_NUM(O), .OUT_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Stimulus state
    logic [W-1:0]                  vld;
    input_write_cmd_pld_t          pld [W];
    logic [O-1:0]                  avld, srdy;
    logic [DB_ENTRY_IDX_WIDTH-1:0] aidx [O];

    // Reference model: per-channel FIFO of expected entries and last winner
    wdb_pld_t q [O][$];
    int       last [O];

    // Values seen from the DUT in the most recent step (pre-edge)
    logic [W-1:0] act_rdy;
    logic [O-1:0] act_alloc;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int tgt_of(input input_write_cmd_pld_t p);
        logic [LOG-1:0] t;
        t = p.cmd_addr[63 -: LOG];
        return int'(t);
    endfunction

    function automatic input_write_cmd_pld_t mk(input int t);
        input_write_cmd_pld_t p;
        p.cmd_addr             = {$urandom, $urandom};
        p.cmd_addr[63 -: LOG]  = LOG'(t);
        p.cmd_txnid            = TXNID_WIDTH'($urandom);
        p.cmd_sideband         = SIDEBAND_WIDTH'($urandom);
        p.strb                 = STRB_WIDTH'($urandom);
        p.data                 = {$urandom, $urandom};
        return p;
    endfunction

    function automatic wdb_pld_t exp_entry(input input_write_cmd_pld_t p,
                                           input logic [DB_ENTRY_IDX_WIDTH-1:0] id);
        wdb_pld_t e;
        e.cmd.cmd_addr     = p.cmd_addr;
        e.cmd.cmd_txnid    = p.cmd_txnid;
        e.cmd.cmd_sideband = p.cmd_sideband;
        e.cmd.cmd_opcode   = OPCODE_WIDTH'(1);
        e.cmd.db_entry_id  = id;
        e.db_entry_id      = id;
        e.strb             = p.strb;
        e.data             = p.data;
        return e;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < O; m++) begin
            q[m].delete();
            last[m] = W - 1;
        end
    endtask

    task automatic drive();
        bus.wr_cmd_vld = vld;
        for (int i = 0; i < W; i++) bus.wr_cmd_pld[i] = pld[i];
        bus.alloc_vld  = avld;
        for (int m = 0; m < O; m++) bus.alloc_idx[m] = aidx[m];
        bus.sel_wr_rdy = srdy;
    endtask

    // One clock cycle: drive, check grants, advance model, check heads.
    task automatic step();
        int           win [O];
        int           i;
        logic [W-1:0] exp_rdy;
        logic [O-1:0] exp_alloc, exp_vld;
        drive();
        #1;
        exp_rdy   = '0;
        exp_alloc = '0;
        for (int m = 0; m < O; m++) begin
            win[m] = -1;
            if (!rst && q[m].size() < D && avld[m]) begin
                for (int k = 1; k <= W; k++) begin
                    i = (last[m] + k) % W;
                    if (win[m] < 0 && vld[i] && tgt_of(pld[i]) == m) win[m] = i;
                end
            end
            if (win[m] >= 0) begin
                exp_rdy[win[m]] = 1'b1;
                exp_alloc[m]    = 1'b1;
            end
        end
        act_rdy   = bus.wr_cmd_rdy;
        act_alloc = bus.alloc_rdy;
        chk("wr_cmd_rdy", act_rdy, exp_rdy);
        chk("alloc_rdy", act_alloc, exp_alloc);
        for (int m = 0; m < O; m++) begin
            if (q[m].size() > 0 && srdy[m]) void'(q[m].pop_front());
            if (win[m] >= 0) begin
                q[m].push_back(exp_entry(pld[win[m]], aidx[m]));
                last[m] = win[m];
            end
        end
        vld = vld & ~exp_rdy;
        @(posedge clk);
        #1;
        exp_vld = '0;
        for (int m = 0; m < O; m++) exp_vld[m] = (q[m].size() > 0);
        chk("sel_wr_vld", bus.sel_wr_vld, exp_vld);
        for (int m = 0; m < O; m++) begin
            if (q[m].size() > 0) begin
                chk("sel_wr_pld", bus.sel_wr_pld[m], q[m][0].cmd);
                chk("sel_wr_data_pld", bus.sel_wr_data_pld[m], q[m][0]);
            end
        end
    endtask

    int total;
    int got6;

    initial begin
        rst  = 1'b1;
        vld  = '0;
        avld = '0;
        srdy = '0;
        for (int i = 0; i < W; i++) pld[i] = mk(i % O);
        for (int m = 0; m < O; m++) aidx[m] = '0;
        model_reset();
        // Requests and allocations present while in reset must be ignored
        vld  = 8'h11;
        avld = '1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_cmd_rdy", bus.wr_cmd_rdy, 0);
        chk("rst_alloc_rdy", bus.alloc_rdy, 0);
        chk("rst_sel_wr_vld", bus.sel_wr_vld, 0);
        vld  = '0;
        avld = '0;
        drive();
        rst = 1'b0;

        // Single write: input 3 -> channel 2, entry 5
        avld    = 4'b0100;
        aidx[2] = 4'd5;
        srdy    = '1;
        pld[3]  = mk(2);
        vld[3]  = 1'b1;
        step();
        chk("single_wr_rdy", act_rdy, 8'h08);
        chk("single_alloc_rdy", act_alloc, 4'h4);
        chk("single_sel_vld", bus.sel_wr_vld, 4'h4);
        chk("single_db_id", bus.sel_wr_pld[2].db_entry_id, 5);
        chk("single_opcode", bus.sel_wr_pld[2].cmd_opcode, 1);
        chk("single_data_db_id", bus.sel_wr_data_pld[2].db_entry_id, 5);

        // Contention on channel 0: 0,1,2,0,1,2 one per cycle
        avld = '1;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 3; i++) begin
                pld[i] = mk(0);
                vld[i] = 1'b1;
            end
            for (int m = 0; m < O; m++) aidx[m] = DB_ENTRY_IDX_WIDTH'($urandom);
            step();
            chk("rr_grant", act_rdy, 1 << (c % 3));
        end
        vld = '0;
        step();

        // Backpressure on channel 1: two granted, third waits, then drains
        srdy = 4'b1101;
        for (int i = 4; i < 7; i++) begin
            pld[i] = mk(1);
            vld[i] = 1'b1;
        end
        total = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            total += $countones(act_rdy);
        end
        chk("bp_granted", total, 2);
        srdy = '1;
        got6 = 0;
        for (int c = 0; c < 4 && got6 == 0; c++) begin
            step();
            if (act_rdy[6]) got6 = 1;
        end
        chk("bp_third_granted", got6, 1);
        vld = '0;
        repeat (2) step();

        // No allocation on channel 3 blocks the grant until alloc_vld rises
        avld   = 4'b0111;
        pld[7] = mk(3);
        vld[7] = 1'b1;
        step();
        chk("noalloc_wr_rdy", act_rdy, 0);
        chk("noalloc_alloc_rdy", act_alloc, 0);
        avld = '1;
        step();
        chk("alloc_wr_rdy", act_rdy, 8'h80);
        chk("alloc_alloc_rdy", act_alloc, 4'h8);
        vld = '0;
        repeat (2) step();

        // Parallel: four channels grant in the same cycle
        for (int i = 0; i < 4; i++) begin
            pld[i] = mk(i);
            vld[i] = 1'b1;
        end
        step();
        chk("par_wr_rdy", act_rdy, 8'h0F);
        chk("par_alloc_rdy", act_alloc, 4'hF);
        chk("par_sel_vld", bus.sel_wr_vld, 4'hF);

        // Fill every queue to 2 entries, then reset mid-cycle
        srdy = '0;
        for (int i = 0; i < W; i++) begin
            pld[i] = mk(i % O);
            vld[i] = 1'b1;
        end
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_sel_vld", bus.sel_wr_vld, 0);
        chk("midrst_wr_rdy", bus.wr_cmd_rdy, 0);
        chk("midrst_alloc_rdy", bus.alloc_rdy, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        vld    = '0;
        srdy   = '1;
        pld[2] = mk(0);
        pld[5] = mk(0);
        vld[2] = 1'b1;
        vld[5] = 1'b1;
        step();
        chk("post_rst_grant", act_rdy, 8'h04);
        vld = '0;

        // Randomized traffic; pending requests hold until granted
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < W; i++) begin
                if (!vld[i] && $urandom_range(0, 2) == 0) begin
                    pld[i] = mk(int'($urandom_range(0, O - 1)));
                    vld[i] = 1'b1;
                end
            end
            for (int m = 0; m < O; m++) begin
                avld[m] = ($urandom_range(0, 9) < 8);
                srdy[m] = ($urandom_range(0, 9) < 7);
                aidx[m] = DB_ENTRY_IDX_WIDTH'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
